// File: rtl/seek_f_pipe_pkg.sv
// Shared constants and helpers for the seek_f two-stage lane pipeline.
package seek_f_pipe_pkg;

    localparam int DW_DEF    = 15;
    localparam int SHIFT_DEF = 20;
    localparam int CNTW_DEF  = 16;

    localparam logic MODE_FULL = 1'b0;
    localparam logic MODE_NOC  = 1'b1;

    function automatic int fw_of(input int dw, input int shift);
        return dw + shift + 1;
    endfunction

endpackage

// File: rtl/seek_f_lane.sv
// One lane of seek_f: S1 holds S, e[EB] and K; S2 holds f and uflow.
module seek_f_lane
    import seek_f_pipe_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int FW    = fw_of(DW_DEF, SHIFT_DEF)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld1_i,
    input  logic          ld2_i,
    input  logic          v1_i,
    input  logic          mode_i,
    input  logic [DW-1:0] c_i,
    input  logic [DW-1:0] e_i,
    output logic [FW-1:0] f_o,
    output logic          uflow_o
);

    localparam int SW = DW - 1;
    localparam int UW = DW + SHIFT;
    localparam int MW = (FW > UW) ? FW : UW;

    logic [SW-1:0] s_q, s_d;
    logic          eb_q;
    logic [1:0]    k_q, k_d;
    logic [FW-1:0] f_q, f_d;
    logic          uf_q, uf_d;

    logic [MW-1:0] t_w, sub_w, diff_w;

    always_comb begin
        s_d = SW'(e_i[DW-3:0]) + SW'(e_i[DW-2]);
        k_d = (mode_i == MODE_NOC) ? 2'b00 : c_i[DW-1:DW-2];
    end

    // Wide enough for both the FW-bit result and the true comparison.
    always_comb begin
        t_w    = MW'(s_q) << SHIFT;
        sub_w  = MW'(eb_q) + MW'(k_q);
        diff_w = t_w - sub_w;
        f_d    = '0;
        uf_d   = 1'b0;
        if (v1_i) begin
            f_d  = diff_w[FW-1:0];
            uf_d = (t_w < sub_w);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q  <= '0;
            eb_q <= 1'b0;
            k_q  <= '0;
        end else if (ld1_i) begin
            s_q  <= s_d;
            eb_q <= e_i[DW-2];
            k_q  <= k_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q  <= '0;
            uf_q <= 1'b0;
        end else if (ld2_i) begin
            f_q  <= f_d;
            uf_q <= uf_d;
        end
    end

    assign f_o     = f_q;
    assign uflow_o = uf_q;

endmodule

// File: rtl/seek_f_pipe.sv
// seek_f pipeline top: shared valid/ready control around LANES lane datapaths.
module seek_f_pipe
    import seek_f_pipe_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int LANES = 4,
    parameter int SHIFT = SHIFT_DEF,
    parameter int FW    = fw_of(DW, SHIFT),
    parameter int CNTW  = CNTW_DEF
) (
    input  logic                 clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mode,
    input  logic [LANES*DW-1:0] c,
    input  logic [LANES*DW-1:0] e,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*FW-1:0] f,
    output logic [LANES-1:0]    uflow,
    output logic [CNTW-1:0]     count
);

    logic            s1_valid_q, s1_valid_d;
    logic            out_valid_q, out_valid_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            adv1, adv2, ld1;

    always_comb begin
        adv2        = !out_valid_q || out_ready;
        adv1        = !s1_valid_q || adv2;
        ld1         = adv1 && in_valid;
        s1_valid_d  = adv1 ? in_valid : s1_valid_q;
        out_valid_d = adv2 ? s1_valid_q : out_valid_q;
        cnt_d       = cnt_q;
        if (out_valid_q && out_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        seek_f_lane #(
            .DW    (DW),
            .SHIFT (SHIFT),
            .FW    (FW)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .ld1_i   (ld1),
            .ld2_i   (adv2),
            .v1_i    (s1_valid_q),
            .mode_i  (mode),
            .c_i     (c[i*DW +: DW]),
            .e_i     (e[i*DW +: DW]),
            .f_o     (f[i*FW +: FW]),
            .uflow_o (uflow[i])
        );
    end

    assign in_ready  = adv1;
    assign out_valid = out_valid_q;
    assign count     = cnt_q;

endmodule

// File: tb/tb_seek_f_pipe.sv
// Directed bench for seek_f_pipe: arithmetic, handshake, reset and wrap.
module tb_seek_f_pipe;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [59:0]  c;
    logic [59:0]  e;
    logic         out_valid;
    logic         out_ready;
    logic [143:0] f;
    logic [3:0]   uflow;
    logic [15:0]  count;

    logic         in_ready2;
    logic         out_valid2;
    logic [143:0] f2;
    logic [3:0]   uflow2;
    logic [3:0]   count2;

    int checks = 0;
    int errors = 0;

    seek_f_pipe u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .c         (c),
        .e         (e),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .uflow     (uflow),
        .count     (count)
    );

    seek_f_pipe #(.CNTW(4)) u_dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .mode      (mode),
        .c         (c),
        .e         (e),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .f         (f2),
        .uflow     (uflow2),
        .count     (count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs,
                       input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int         sent, rcv, ovn;
    logic       saw_stall, stalled_prev, stale, gap;
    logic [35:0] prev_f;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mode = 1'b0; c = '0; e = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov", out_valid, 0);
        chk("rst_f", f, 0);
        chk("rst_uf", uflow, 0);
        chk("rst_cnt", count, 0);
        rst_n = 1'b1;
        tick();
        chk("rdy_after_rst", in_ready, 1);

        // Full correction, lane 0
        mode = 1'b0; c = '0; e = '0;
        c[14:0] = 15'h6000; e[14:0] = 15'h2001; in_valid = 1'b1;
        tick(); in_valid = 1'b0; tick();
        chk("full_ov", out_valid, 1);
        chk("full_f0", f[35:0], 36'h1FFFFC);
        chk("full_uf", uflow, 0);
        tick();
        chk("drain_ov", out_valid, 0);
        chk("drain_f", f, 0);
        chk("cnt1", count, 1);

        // No-c mode, lanes 0 and 1
        mode = 1'b1; c = '0; e = '0;
        c[14:0] = 15'h6000; e[14:0] = 15'h2001; e[29:15] = 15'h0005;
        in_valid = 1'b1;
        tick(); in_valid = 1'b0; tick();
        chk("noc_f0", f[35:0], 36'h1FFFFF);
        chk("noc_f1", f[71:36], 36'h500000);

        // Underflow on every lane
        mode = 1'b0; c = {4{15'h2000}}; e = '0; in_valid = 1'b1;
        tick(); in_valid = 1'b0; tick();
        chk("uf_f", f, {4{36'hFFFFFFFFF}});
        chk("uf_flag", uflow, 4'hF);

        // Independent lanes with different K
        c = {15'h0000, 15'h7FFF, 15'h4000, 15'h2000};
        e = {15'h2000, 15'h3FFF, 15'h0005, 15'h0000};
        in_valid = 1'b1;
        tick(); in_valid = 1'b0; tick();
        chk("mix_f", f, {36'h0000FFFFF, 36'h1FFFFFFFC,
                         36'h0004FFFFE, 36'hFFFFFFFFF});
        chk("mix_uf", uflow, 4'b0001);
        tick();
        chk("cnt4", count, 4);

        // Back-pressure over 8 beats
        rst_n = 1'b0; #1; rst_n = 1'b1;
        mode = 1'b0; c = '0; e = '0;
        sent = 0; rcv = 0; saw_stall = 1'b0; stalled_prev = 1'b0;
        prev_f = '0;
        for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid = (sent < 8);
            e = '0;
            e[14:0] = 15'(sent + 1);
            #1;
            if (out_valid && stalled_prev) chk("bp_hold", f[35:0], prev_f);
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (out_valid && out_ready) begin
                chk("bp_data", f[35:0], 36'(rcv + 1) << 20);
                rcv++;
            end
            stalled_prev = out_valid && !out_ready;
            prev_f = f[35:0];
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_rcv", rcv, 8);
        chk("bp_stall", saw_stall, 1);
        chk("bp_cnt", count, 8);

        // Reset with both stages full
        out_ready = 1'b0; e = '0; e[14:0] = 15'h0009; in_valid = 1'b1;
        tick(); tick();
        rst_n = 1'b0; #1;
        chk("mid_ov", out_valid, 0);
        chk("mid_f", f, 0);
        chk("mid_cnt", count, 0);
        in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (out_valid) stale = 1'b1;
        end
        chk("no_stale", stale, 0);

        // Full throughput and counter wrap on the 4-bit instance
        gap = 1'b0; ovn = 0;
        for (int k = 0; k < 22; k++) begin
            in_valid = (k < 17);
            e = '0;
            e[14:0] = 15'(k + 3);
            #1;
            if (!in_ready) gap = 1'b1;
            if (out_valid) ovn++;
            tick();
        end
        in_valid = 1'b0;
        chk("thr_rdy", gap, 0);
        chk("thr_ov", ovn, 17);
        chk("thr_cnt", count, 17);
        chk("wrap_cnt", count2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
